regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width.
REQ-002 The block SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 The block SHALL have parameter NRD, default 2, read-port count.
REQ-004 The block SHALL have parameter NWR, default 2, write-port count.
REQ-005 The block SHALL have parameter BYPASS, default 1, same-cycle write-to-read forwarding enable.
REQ-006 The block SHALL have parameter RST_VAL, default 32'd4, reset fill value for registers 1..NREG-1.
REQ-007 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 The block SHALL have port reset_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-009 The block SHALL have ports rd_addr[NRD], input, AW each, read addresses.
REQ-010 The block SHALL have ports rd_data[NRD], output, XLEN each, read data.
REQ-011 The block SHALL have ports rd_busy[NRD], output, 1 each, scoreboard busy flag of the addressed register.
REQ-012 The block SHALL have ports wr_en[NWR], input, 1 each, write strobes.
REQ-013 The block SHALL have ports wr_addr[NWR], input, AW each, write addresses.
REQ-014 The block SHALL have ports wr_data[NWR], input, XLEN each, write data.
REQ-015 The block SHALL have port alloc_en, input, 1, marks alloc_addr busy (pending producer).
REQ-016 The block SHALL have port alloc_addr, input, AW, register to mark busy.
REQ-017 The block SHALL have port flush, input, 1, clears all busy bits.
REQ-018 The block SHALL have port wr_conflict, output, 1, registered flag: two or more ports wrote the same nonzero address in the previous cycle.

Function
REQ-019 Register 0 SHALL read as 0 on every port, never be written, never be busy; alloc/write to address 0 ignored.
REQ-020 Reads SHALL be combinational; with no same-cycle write to rd_addr, rd_data equals array content.
REQ-021 Write with wr_en=1, wr_addr!=0 SHALL update the array at the next rising clk edge.
REQ-022 Several ports writing one address in the same cycle: highest-index port SHALL win for both array and bypass.
REQ-023 BYPASS=1: rd_data SHALL equal the winning same-cycle wr_data for a matching nonzero rd_addr; BYPASS=0: pre-write content.
REQ-024 busy[r] SHALL set at the edge after alloc_en=1 with alloc_addr=r.
REQ-025 busy[r] SHALL clear at the edge after any wr_en with wr_addr=r.
REQ-026 alloc and write to the same r in one cycle: busy[r] SHALL remain/become 1 (newer producer wins).
REQ-027 flush=1 SHALL clear all busy bits at the next edge, overriding a same-cycle alloc; register data is unaffected.
REQ-028 rd_busy SHALL reflect registered busy; with BYPASS=1 a same-cycle matching write forces rd_busy=0.
REQ-029 wr_conflict SHALL be 1 for exactly the cycle after a conflicting cycle, else 0.

Reset
REQ-030 reset_n=0 SHALL asynchronously set registers 1..NREG-1 to RST_VAL, all busy bits to 0, wr_conflict to 0.
REQ-031 Writes, allocs, flush SHALL be ignored while reset_n=0; reset mid-operation discards pending updates.
REQ-032 Reset release SHALL be taken synchronously by the environment; first update occurs at the first edge with reset_n=1.

Structure
REQ-033 Shared package regfile_pkg SHALL hold default XLEN/NREG/RST_VAL constants and the address-width function.
REQ-034 Scoreboard SHALL be the sub-module regfile_scoreboard (busy vector, alloc/clear/flush priority, rd_busy lookup).
REQ-035 Array, write arbitration, bypass and conflict detection SHALL reside in regfile_mp.

Verification
REQ-036 Reset then read x1,x31 -> rd_data 0x4 each, rd_busy 0; read x0 -> 0.
REQ-037 wr0 x5=0xDEADBEEF, rd0 x5 same cycle -> BYPASS=1: 0xDEADBEEF; BYPASS=0: 0x4, then 0xDEADBEEF next cycle.
REQ-038 wr0 x7=0x11, wr1 x7=0x22 same cycle -> x7 reads 0x22 after edge; wr_conflict=1 one cycle only.
REQ-039 alloc x9; next cycle rd_busy=1; wr x9=0x55 with alloc x9 -> busy stays 1; wr x9 alone -> busy 0.
REQ-040 alloc x3 with flush -> busy x3 0; wr x0=0xFFFF_FFFF -> x0 reads 0, no busy, no conflict.
REQ-041 reset_n low mid-stream with wr x4=0x99 pending -> x4 reads 0x4 immediately, busy all 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address-width helper for the multi-port register file
// Purpose: default data width, register count and reset fill value, plus the
// address-width function used by the interface, top and scoreboard.
package regfile_pkg;

  localparam int          DEF_XLEN    = 32;
  localparam int          DEF_NREG    = 32;
  localparam logic [31:0] DEF_RST_VAL = 32'd4;

  function automatic int addr_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/scoreboard bus of the multi-port register file
// Purpose: bundles every non-clock/reset signal of regfile_mp.
// Ports (slave view):
//   in : rd_addr[NRD], wr_en/wr_addr/wr_data[NWR], alloc_en, alloc_addr, flush
//   out: rd_data[NRD], rd_busy[NRD], wr_conflict
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) ();

  localparam int AW = addr_w(NREG);

  logic [AW-1:0]   rd_addr   [NRD];
  logic [XLEN-1:0] rd_data   [NRD];
  logic            rd_busy   [NRD];

  logic            wr_en     [NWR];
  logic [AW-1:0]   wr_addr   [NWR];
  logic [XLEN-1:0] wr_data   [NWR];

  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            flush;
  logic            wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, wr_conflict
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard for pending register producers
// Purpose: one busy bit per register; alloc sets, write clears, flush clears all.
// Ports:
//   in : clk, reset_n, alloc_en, alloc_addr, flush, wr_en[NWR], wr_addr[NWR],
//        rd_addr[NRD], rd_fwd[NRD] (same-cycle forwarded write hits the read)
//   out: rd_busy[NRD]
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = addr_w(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic          flush,
  input  logic          wr_en   [NWR],
  input  logic [AW-1:0] wr_addr [NWR],
  input  logic [AW-1:0] rd_addr [NRD],
  input  logic          rd_fwd  [NRD],
  output logic          rd_busy [NRD]
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Order matters: write-clear, then alloc-set (newer producer wins),
  // then flush overrides everything. Register 0 is never busy.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) busy_d[wr_addr[w]] = 1'b0;
    end
    if (alloc_en) busy_d[alloc_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  // A forwarded write delivers the value this cycle, so the reader need not stall.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_busy[p] = busy_q[rd_addr[p]] & ~rd_fwd[p];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, scoreboard and write-conflict flag
// Purpose: NREG x XLEN array, x0 hardwired to zero, NWR write ports
// (highest index wins), NRD combinational read ports with optional forwarding.
// Ports:
//   in : clk, reset_n (async, active-low)
//   bus: regfile_mp_if.slave (reads, writes, alloc/flush, rd_busy, wr_conflict)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int              XLEN    = DEF_XLEN,
  parameter int              NREG    = DEF_NREG,
  parameter int              NRD     = 2,
  parameter int              NWR     = 2,
  parameter int              BYPASS  = 1,
  parameter logic [XLEN-1:0] RST_VAL = XLEN'(DEF_RST_VAL)
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);

  localparam int AW = addr_w(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            conflict_q;
  logic            conflict_d;
  logic            fwd_hit  [NRD];
  logic [XLEN-1:0] fwd_data [NRD];

  // Ascending port order lets the highest-index writer overwrite the others.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWR; w++) begin
      if (bus.wr_en[w] && (bus.wr_addr[w] != '0)) begin
        regs_d[bus.wr_addr[w]] = bus.wr_data[w];
      end
    end
    regs_d[0] = '0;
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] &&
            (bus.wr_addr[i] == bus.wr_addr[j]) && (bus.wr_addr[i] != '0)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Forwarding uses the same ascending priority as the array update.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      for (int w = 0; w < NWR; w++) begin
        if ((BYPASS != 0) && bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p]) &&
            (bus.rd_addr[p] != '0)) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = bus.wr_data[w];
        end
      end
      if (bus.rd_addr[p] == '0) bus.rd_data[p] = '0;
      else if (fwd_hit[p])      bus.rd_data[p] = fwd_data[p];
      else                      bus.rd_data[p] = regs_q[bus.rd_addr[p]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= (r == 0) ? '0 : RST_VAL;
      end
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.wr_conflict = conflict_q;

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .flush      (bus.flush),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .rd_addr    (bus.rd_addr),
    .rd_fwd     (fwd_hit),
    .rd_busy    (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (bypass on and off)
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) b1 ();
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) b0 ();

  // The no-bypass instance sees exactly the same stimulus.
  assign b0.rd_addr    = b1.rd_addr;
  assign b0.wr_en      = b1.wr_en;
  assign b0.wr_addr    = b1.wr_addr;
  assign b0.wr_data    = b1.wr_data;
  assign b0.alloc_en   = b1.alloc_en;
  assign b0.alloc_addr = b1.alloc_addr;
  assign b0.flush      = b1.flush;

  regfile_mp #(.BYPASS(1)) u_byp (.clk(clk), .reset_n(reset_n), .bus(b1));
  regfile_mp #(.BYPASS(0)) u_nob (.clk(clk), .reset_n(reset_n), .bus(b0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      b1.rd_addr[p] = '0;
      b1.wr_en[p]   = 1'b0;
      b1.wr_addr[p] = '0;
      b1.wr_data[p] = '0;
    end
    b1.alloc_en   = 1'b0;
    b1.alloc_addr = '0;
    b1.flush      = 1'b0;
  endtask

  // Advance one edge, then drive fresh idle inputs 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    b1.rd_addr[0] = 5'd1;
    b1.rd_addr[1] = 5'd31;
    #1;
    chk("rst_x1", b1.rd_data[0], 32'h4);
    chk("rst_x31", b1.rd_data[1], 32'h4);
    chk("rst_busy", b1.rd_busy[0], 1'b0);
    chk("rst_conf", b1.wr_conflict, 1'b0);
    reset_n = 1'b1;

    cyc();
    b1.rd_addr[0] = 5'd1;
    b1.rd_addr[1] = 5'd31;
    #1;
    chk("x1_after_rel", b1.rd_data[0], 32'h4);
    chk("x31_after_rel", b1.rd_data[1], 32'h4);
    chk("x31_busy", b1.rd_busy[1], 1'b0);
    b1.rd_addr[0] = 5'd0;
    #1;
    chk("x0_zero", b1.rd_data[0], 32'h0);

    // Bypass of a single write.
    cyc();
    b1.wr_en[0] = 1'b1; b1.wr_addr[0] = 5'd5; b1.wr_data[0] = 32'hDEADBEEF;
    b1.rd_addr[0] = 5'd5;
    #1;
    chk("byp_x5", b1.rd_data[0], 32'hDEADBEEF);
    chk("nob_x5_old", b0.rd_data[0], 32'h4);
    cyc();
    b1.rd_addr[0] = 5'd5;
    #1;
    chk("byp_x5_next", b1.rd_data[0], 32'hDEADBEEF);
    chk("nob_x5_next", b0.rd_data[0], 32'hDEADBEEF);

    // Two writers to one address: port 1 wins, conflict flagged one cycle.
    cyc();
    b1.wr_en[0] = 1'b1; b1.wr_addr[0] = 5'd7; b1.wr_data[0] = 32'h11;
    b1.wr_en[1] = 1'b1; b1.wr_addr[1] = 5'd7; b1.wr_data[1] = 32'h22;
    b1.rd_addr[1] = 5'd7;
    #1;
    chk("byp_x7_win", b1.rd_data[1], 32'h22);
    chk("conf_before", b1.wr_conflict, 1'b0);
    cyc();
    b1.rd_addr[1] = 5'd7;
    #1;
    chk("x7_array", b0.rd_data[1], 32'h22);
    chk("conf_set", b1.wr_conflict, 1'b1);
    chk("conf_set_nob", b0.wr_conflict, 1'b1);
    cyc();
    #1;
    chk("conf_clear", b1.wr_conflict, 1'b0);

    // Scoreboard: alloc, alloc+write, write alone.
    cyc();
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd9; b1.rd_addr[0] = 5'd9;
    #1;
    chk("busy9_not_yet", b1.rd_busy[0], 1'b0);
    cyc();
    b1.rd_addr[0] = 5'd9;
    #1;
    chk("busy9_set", b1.rd_busy[0], 1'b1);
    cyc();
    b1.wr_en[0] = 1'b1; b1.wr_addr[0] = 5'd9; b1.wr_data[0] = 32'h55;
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd9; b1.rd_addr[0] = 5'd9;
    #1;
    chk("busy9_fwd_byp", b1.rd_busy[0], 1'b0);
    chk("busy9_fwd_nob", b0.rd_busy[0], 1'b1);
    cyc();
    b1.rd_addr[0] = 5'd9;
    #1;
    chk("busy9_stays", b1.rd_busy[0], 1'b1);
    chk("x9_55", b0.rd_data[0], 32'h55);
    cyc();
    b1.wr_en[1] = 1'b1; b1.wr_addr[1] = 5'd9; b1.wr_data[1] = 32'h66;
    b1.rd_addr[0] = 5'd9;
    #1;
    chk("busy9_wr_nob", b0.rd_busy[0], 1'b1);
    cyc();
    b1.rd_addr[0] = 5'd9;
    #1;
    chk("busy9_cleared", b1.rd_busy[0], 1'b0);
    chk("x9_66", b1.rd_data[0], 32'h66);

    // Flush overrides a same-cycle alloc.
    cyc();
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd3;
    cyc();
    b1.rd_addr[0] = 5'd3;
    #1;
    chk("busy3_set", b1.rd_busy[0], 1'b1);
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd3; b1.flush = 1'b1;
    cyc();
    b1.rd_addr[0] = 5'd3;
    #1;
    chk("busy3_flushed", b1.rd_busy[0], 1'b0);
    chk("x3_data_kept", b1.rd_data[0], 32'h4);

    // Register 0 ignores writes and allocs.
    cyc();
    b1.wr_en[0] = 1'b1; b1.wr_addr[0] = 5'd0; b1.wr_data[0] = 32'hFFFF_FFFF;
    b1.wr_en[1] = 1'b1; b1.wr_addr[1] = 5'd0; b1.wr_data[1] = 32'hFFFF_FFFF;
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd0;
    #1;
    chk("x0_no_byp", b1.rd_data[0], 32'h0);
    cyc();
    #1;
    chk("x0_still0", b1.rd_data[0], 32'h0);
    chk("x0_not_busy", b1.rd_busy[0], 1'b0);
    chk("x0_no_conf", b1.wr_conflict, 1'b0);

    // Asynchronous reset mid-stream.
    cyc();
    b1.wr_en[0] = 1'b1; b1.wr_addr[0] = 5'd8; b1.wr_data[0] = 32'h77;
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd4;
    cyc();
    b1.rd_addr[0] = 5'd8; b1.rd_addr[1] = 5'd4;
    #1;
    chk("x8_77", b1.rd_data[0], 32'h77);
    chk("busy4_set", b1.rd_busy[1], 1'b1);
    b1.wr_en[0] = 1'b1; b1.wr_addr[0] = 5'd4; b1.wr_data[0] = 32'h99;
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd6;
    #1;
    reset_n = 1'b0;
    b1.wr_en[0] = 1'b0;
    b1.alloc_en = 1'b0;
    #1;
    chk("rst_x4", b1.rd_data[1], 32'h4);
    chk("rst_x8", b1.rd_data[0], 32'h4);
    chk("rst_busy4", b1.rd_busy[1], 1'b0);
    // Writes and allocs held across an edge during reset are ignored.
    b1.wr_en[0] = 1'b1; b1.alloc_en = 1'b1; b1.alloc_addr = 5'd4;
    @(posedge clk);
    #1;
    idle();
    b1.rd_addr[1] = 5'd4;
    #1;
    chk("rst_hold_x4", b1.rd_data[1], 32'h4);
    chk("rst_hold_busy4", b1.rd_busy[1], 1'b0);
    reset_n = 1'b1;
    cyc();
    b1.rd_addr[1] = 5'd4;
    #1;
    chk("post_rst_x4", b1.rd_data[1], 32'h4);
    chk("post_rst_busy4", b1.rd_busy[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
